dma_burst_controller: RTL and testbench

//   DMA engine sequencing device-to-memory block transfers. Takes a start command (cmd, base

---
 rtl/dma_burst_controller.sv | 158 +++++++++++++++
 tb/tb_dma_burst_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_controller.sv
// DMA engine that moves a device buffer into data memory in 4-word bursts.
// It arbitrates for the bus via BR/BG, can release the bus between bursts, and signals completion with dma_end_int.
module dma_burst_controller #(
  parameter int WORD_SIZE   = 16,
  parameter int BURST_WORDS = 4,
  parameter int STEAL_GAP   = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd,
  input  logic [WORD_SIZE-1:0]            cmd_addr,
  input  logic [WORD_SIZE-1:0]            cmd_len,
  input  logic                            BG,
  output logic                            BR,
  input  logic [BURST_WORDS*WORD_SIZE-1:0] dev_data,
  output logic [WORD_SIZE-1:0]            dev_idx,
  output logic [WORD_SIZE-1:0]            d_address,
  output logic [BURST_WORDS*WORD_SIZE-1:0] d_data,
  output logic                            d_writeM,
  input  logic                            doneWrite_d,
  output logic                            busy,
  output logic                            dma_end_int
);

  localparam int W  = WORD_SIZE;
  localparam int DW = BURST_WORDS * WORD_SIZE;
  localparam int GW = (STEAL_GAP > 2) ? $clog2(STEAL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((STEAL_GAP > 0) ? STEAL_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_NEXT,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    base_q, base_d;
  logic [W-1:0]    nbursts_q, nbursts_d;
  logic [W-1:0]    k_q, k_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            br_q, br_d;
  logic            wr_q, wr_d;
  logic            busy_q, busy_d;
  logic            end_q, end_d;
  logic [W-1:0]    addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [W-1:0]    cmd_nbursts;
  logic            xfer_entry;

  // A partial final burst still occupies a whole burst slot.
  assign cmd_nbursts = {2'b00, cmd_len[W-1:2]} + {{(W-1){1'b0}}, |cmd_len[1:0]};

  // NOTE: memories and state use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      nbursts_q <= '0;
      k_q       <= '0;
      gap_q     <= '0;
      br_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      nbursts_q <= nbursts_d;
      k_q       <= k_d;
      gap_q     <= gap_d;
      br_q      <= br_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      end_q     <= end_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    nbursts_d = nbursts_q;
    k_d       = k_q;
    gap_d     = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd) begin
          base_d    = cmd_addr;
          nbursts_d = cmd_nbursts;
          k_d       = '0;
          state_d   = (cmd_nbursts == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (BG) state_d = S_XFER;
      end
      S_XFER: begin
        // A completed write wins over a simultaneous grant loss.
        if (doneWrite_d) begin
          k_d = k_q + W'(1);
          if (k_q + W'(1) == nbursts_q) begin
            state_d = S_DONE;
          end else if (STEAL_GAP == 0) begin
            state_d = S_NEXT;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end
        end else if (!BG) begin
          state_d = S_REQ;
        end
      end
      S_NEXT: begin
        state_d = BG ? S_XFER : S_REQ;
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_REQ;
        else             gap_d   = gap_q - GW'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear as registered values
  // in the same cycle the FSM enters that state.
  always_comb begin
    br_d       = (state_d == S_REQ) || (state_d == S_XFER) || (state_d == S_NEXT);
    wr_d       = (state_d == S_XFER);
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    end_d      = (state_d == S_DONE);
    xfer_entry = (state_d == S_XFER) && (state_q != S_XFER);
    addr_d     = xfer_entry ? base_q + (k_q << 2) : addr_q;
    data_d     = xfer_entry ? dev_data : data_q;
  end

  assign BR          = br_q;
  assign d_writeM    = wr_q;
  assign busy        = busy_q;
  assign dma_end_int = end_q;
  assign d_address   = addr_q;
  assign d_data      = data_q;
  assign dev_idx     = k_q;

endmodule

// File: tb/tb_dma_burst_controller.sv
// Directed bench for dma_burst_controller: a vector table driven by a simple bus/memory
// responder, plus hand-stepped sequences for grant withholding, preemption and reset.
module tb_dma_burst_controller;

  localparam int W  = 16;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd;
  logic [W-1:0]  cmd_addr;
  logic [W-1:0]  cmd_len;
  logic          bg;
  logic          done_w;
  logic          sel;

  logic          br0, wm0, busy0, end0;
  logic [W-1:0]  idx0, addr0;
  logic [DW-1:0] data0, dev0;
  logic          br1, wm1, busy1, end1;
  logic [W-1:0]  idx1, addr1;
  logic [DW-1:0] data1, dev1;

  logic          cur_br, cur_wm, cur_busy, cur_end;
  logic [W-1:0]  cur_idx, cur_addr;
  logic [DW-1:0] cur_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pattern(input logic [W-1:0] k);
    return {16'hD000 + k, 16'hC000 + k, 16'hB000 + k, 16'hA000 + k};
  endfunction

  assign dev0 = pattern(idx0);
  assign dev1 = pattern(idx1);

  dma_burst_controller #(.WORD_SIZE(16), .BURST_WORDS(4), .STEAL_GAP(1)) dut0 (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .BG(bg), .BR(br0), .dev_data(dev0), .dev_idx(idx0), .d_address(addr0),
    .d_data(data0), .d_writeM(wm0), .doneWrite_d(done_w), .busy(busy0),
    .dma_end_int(end0)
  );

  dma_burst_controller #(.WORD_SIZE(16), .BURST_WORDS(4), .STEAL_GAP(0)) dut1 (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .BG(bg), .BR(br1), .dev_data(dev1), .dev_idx(idx1), .d_address(addr1),
    .d_data(data1), .d_writeM(wm1), .doneWrite_d(done_w), .busy(busy1),
    .dma_end_int(end1)
  );

  always_comb begin
    cur_br   = sel ? br1   : br0;
    cur_wm   = sel ? wm1   : wm0;
    cur_busy = sel ? busy1 : busy0;
    cur_end  = sel ? end1  : end0;
    cur_idx  = sel ? idx1  : idx0;
    cur_addr = sel ? addr1 : addr0;
    cur_data = sel ? data1 : data0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    cmd    = 1'b0;
    bg     = 1'b0;
    done_w = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] len;
    logic         sel;
    int           inj;
    int           nb;
    logic [W-1:0] ea0;
    logic [W-1:0] ea1;
    logic [W-1:0] ea2;
    int           gaps;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [W-1:0] exp_addr(input vec_t v, input int i);
    case (i)
      0:       return v.ea0;
      1:       return v.ea1;
      default: return v.ea2;
    endcase
  endfunction

  // BG follows BR one cycle later; doneWrite pulses on the third cycle of d_writeM.
  task automatic run_vec(input vec_t v, input int vi);
    logic [W-1:0]  got_addr [$];
    logic [W-1:0]  got_idx  [$];
    logic [DW-1:0] got_data [$];
    int br_cnt = 0, wm_cnt = 0, n_end = 0, end_cyc = -1, last_done = -1;
    int first_br = -1, gap_cyc = 0, viol = 0, br_high = 0;
    logic prev_wm = 1'b0;
    string tag = $sformatf("v%0d", vi);

    do_reset();
    sel      = v.sel;
    cmd_addr = v.addr;
    cmd_len  = v.len;
    cmd      = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (cur_br && first_br < 0) first_br = cyc;
      if (cur_br) br_high++;
      if (!cur_br && cur_wm) viol++;
      if (!cur_br && cur_busy) gap_cyc++;
      if (cur_wm && !prev_wm) begin
        got_addr.push_back(cur_addr);
        got_idx.push_back(cur_idx);
        got_data.push_back(cur_data);
      end
      prev_wm = cur_wm;
      if (cur_end) begin
        n_end++;
        if (end_cyc < 0) end_cyc = cyc;
      end
      if (end_cyc > 0 && cyc >= end_cyc + 2) break;
      cmd = (cyc == v.inj);
      if (cyc == v.inj) begin
        cmd_addr = 16'h0800;
        cmd_len  = 16'd4;
      end
      br_cnt = cur_br ? br_cnt + 1 : 0;
      bg     = (br_cnt >= 1);
      wm_cnt = cur_wm ? wm_cnt + 1 : 0;
      done_w = (wm_cnt == 3);
      if (done_w) last_done = cyc;
    end

    check({tag, "_finished"}, end_cyc > 0, 1);
    check({tag, "_bursts"}, got_addr.size(), v.nb);
    for (int i = 0; i < got_addr.size() && i < v.nb; i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr(v, i));
      check($sformatf("%s_idx%0d", tag, i), got_idx[i], i);
      check($sformatf("%s_data%0d", tag, i), got_data[i], pattern(W'(i)));
    end
    check({tag, "_end_pulses"}, n_end, 1);
    if (v.nb > 0) begin
      check({tag, "_br_latency"}, first_br, 1);
      check({tag, "_end_latency"}, end_cyc, last_done + 1);
    end else begin
      check({tag, "_end_latency"}, end_cyc, 1);
      check({tag, "_br_never"}, br_high, 0);
    end
    check({tag, "_br_low_busy"}, gap_cyc, v.gaps);
    check({tag, "_br_drop_in_write"}, viol, 0);
    check({tag, "_busy_after"}, cur_busy, 0);
    check({tag, "_br_after"}, cur_br, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    sel      = 1'b0;
    cmd_addr = '0;
    cmd_len  = '0;

    do_reset();
    check("rst_br", br0, 0);
    check("rst_wm", wm0, 0);
    check("rst_busy", busy0, 0);
    check("rst_end", end0, 0);
    check("rst_addr", addr0, 0);
    check("rst_idx", idx0, 0);
    check("rst_data", data0, 0);
    check("rst_br_nogap", br1, 0);

    //            addr      len    sel   inj nb ea0       ea1       ea2       gaps
    vecs[0] = '{16'h0100, 16'd12, 1'b0, 0, 3, 16'h0100, 16'h0104, 16'h0108, 2};
    vecs[1] = '{16'h0100, 16'd0,  1'b0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0};
    vecs[2] = '{16'h0100, 16'd5,  1'b0, 0, 2, 16'h0100, 16'h0104, 16'h0000, 1};
    vecs[3] = '{16'h0100, 16'd4,  1'b0, 0, 1, 16'h0100, 16'h0000, 16'h0000, 0};
    vecs[4] = '{16'hFFFC, 16'd8,  1'b0, 0, 2, 16'hFFFC, 16'h0000, 16'h0000, 1};
    vecs[5] = '{16'h0200, 16'd12, 1'b1, 0, 3, 16'h0200, 16'h0204, 16'h0208, 0};
    vecs[6] = '{16'h0100, 16'd8,  1'b0, 4, 2, 16'h0100, 16'h0104, 16'h0000, 1};
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Grant withheld, then preemption of the second burst and retry.
    do_reset();
    sel = 1'b0; cmd_addr = 16'h0300; cmd_len = 16'd8; bg = 1'b0; cmd = 1'b1;
    @(negedge clk); cmd = 1'b0;
    check("hold_br_on_cmd", br0, 1);
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (!br0 || wm0) viol++;
    end
    check("hold_no_grant", viol, 0);
    bg = 1'b1;
    @(negedge clk);
    check("hold_wm_on_grant", wm0, 1);
    check("hold_addr0", addr0, 16'h0300);
    done_w = 1'b1;
    @(negedge clk); done_w = 1'b0;
    check("hold_gap_wm", wm0, 0);
    check("hold_gap_br", br0, 0);
    check("hold_gap_idx", idx0, 1);
    @(negedge clk);
    check("hold_rereq_br", br0, 1);
    @(negedge clk);
    check("hold_k1_wm", wm0, 1);
    check("hold_k1_addr", addr0, 16'h0304);
    bg = 1'b0;
    @(negedge clk);
    check("pre_wm_drop", wm0, 0);
    check("pre_br_stays", br0, 1);
    check("pre_idx_kept", idx0, 1);
    @(negedge clk);
    check("pre_wait_wm", wm0, 0);
    bg = 1'b1;
    @(negedge clk);
    check("pre_retry_wm", wm0, 1);
    check("pre_retry_addr", addr0, 16'h0304);
    check("pre_retry_data", data0, pattern(16'd1));
    done_w = 1'b1;
    @(negedge clk); done_w = 1'b0;
    check("pre_end", end0, 1);
    check("pre_end_busy", busy0, 0);
    check("pre_end_br", br0, 0);
    @(negedge clk);
    check("pre_end_once", end0, 0);

    // Asynchronous reset in the middle of a write.
    do_reset();
    sel = 1'b0; cmd_addr = 16'h0400; cmd_len = 16'd8; bg = 1'b1; cmd = 1'b1;
    @(negedge clk); cmd = 1'b0;
    @(negedge clk);
    check("arst_pre_wm", wm0, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_wm", wm0, 0);
    check("arst_br", br0, 0);
    check("arst_busy", busy0, 0);
    check("arst_addr", addr0, 0);
    check("arst_data", data0, 0);
    check("arst_idx", idx0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    viol = 0;
    repeat (6) begin
      @(negedge clk);
      if (end0 || br0 || wm0) viol++;
    end
    check("arst_quiet_after", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
